write_back_unit: RTL and testbench
==================================

# write_back_unit

Writeback stage of the ARM-LEGv8 pipeline and the write-side counterpart of operation prep. It accepts completed results from the MEM stage over a valid/ready handshake and selects ALU result or memory read data. It buffers results in a small FIFO and drives the register-file write port (`regWrite`, `writeRegister`, `writeData`) one write per cycle, holding off while the register file signals busy.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries; power of two, ≥ 2.

Ports:
- `clock`  in  1  main clock; all state updates on rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `memValid`  in  1  MEM stage presents a result.
- `memReady`  out  1  unit can accept; combinational, equals `count != DEPTH`.
- `regWriteIn`  in  1  instruction writes a register.
- `memToReg`  in  1  1 = write `memReadData`, 0 = write `aluResult`.
- `destReg`  in  5  destination register address.
- `aluResult`  in  32  ALU output.
- `memReadData`  in  32  data-memory read output.
- `rfBusy`  in  1  register-file write port unavailable this cycle.
- `regWrite`  out  1  write strobe to register file (registered).
- `writeRegister`  out  5  write address (registered).
- `writeData`  out  32  write data (registered).
- `retireCount`  out  16  number of register writes issued, wraps.
- `lookupReg1`, `lookupReg2`  in  5  forwarding lookup addresses (`WB_FORWARD_EN` only).
- `fwdHit1`, `fwdHit2`  out  1  lookup hit (`WB_FORWARD_EN` only).
- `fwdData1`, `fwdData2`  out  32  forwarded data (`WB_FORWARD_EN` only).

## Operation
- Accept on a rising edge with `memValid && memReady`.
- An accepted beat is enqueued only if `regWriteIn == 1` and `destReg != 31`. XZR writes and non-writing instructions are consumed and discarded.
- Enqueued entry: `{destReg, memToReg ? memReadData : aluResult}`. The mux is resolved at accept.
- FIFO: circular, head/tail pointers of `log2(DEPTH)` bits that wrap modulo DEPTH, plus `count` 0..DEPTH.
- Drain: on each edge with `!rfBusy && count != 0`:
  - pop the head;
  - set `regWrite <= 1`, `writeRegister <= head.reg`, `writeData <= head.data`;
  - increment `retireCount`, wrapping 0xFFFF → 0x0000.
- On any other edge `regWrite <= 0`, and `writeRegister`/`writeData` hold their last value.
- Simultaneous push and pop: both occur and `count` is unchanged.
- Full: `memReady = 0`. There is no same-cycle pass-through, even if a pop occurs that edge.
- Empty: no pop, and `regWrite <= 0`.
- `rfBusy` high: no pop and `regWrite <= 0`; contents retained.

## Timing
- Reset (`resetN == 0` at an edge): `count`, pointers, `regWrite`, `writeRegister`, `writeData` and `retireCount` all go to 0. `memReady` is 1 after reset.
- Reset mid-operation discards all buffered entries; a beat presented during the reset edge is not accepted.
- Latency when empty and `rfBusy` low:
  - beat accepted at edge N;
  - `regWrite` high after edge N+1;
  - register file samples at edge N+2.
- Throughput: one write per cycle sustained while `rfBusy` is low.

## Configuration
- `WB_FORWARD_EN` defined:
  - each lookup port searches the valid FIFO entries combinationally;
  - on multiple matches, the youngest (closest to tail) wins;
  - `fwdHitN = 1` and `fwdDataN` is that entry's data;
  - address 31 never hits.
- `WB_FORWARD_EN` undefined: lookup/forward ports and the search logic are absent.

## Test plan
- Single ALU write: `aluResult=0x0000_00AA`, `destReg=5`, `memToReg=0`, accepted at edge N → after edge N+1 `regWrite=1`, `writeRegister=5`, `writeData=0xAA`; `retireCount=1`.
- Memory select and XZR drop: beat with `memToReg=1`, `memReadData=0x1234_5678`, `destReg=3`, then beat with `destReg=31` → exactly one write (reg 3, 0x12345678); `retireCount=1`.
- Backpressure/full, DEPTH=2: hold `rfBusy=1` and offer 3 beats → two accepted, `memReady=0`, third held. Release `rfBusy` → writes issued in order on consecutive cycles, then third accepted.
- Reset mid-operation: two buffered entries with `rfBusy=1`, assert `resetN=0` for one edge → `regWrite=0`, `memReady=1`, no stale writes after release.
- Counter wrap: preload 65535 retirements (or force) plus one write → `retireCount=0x0000`.
- `WB_FORWARD_EN`: entries reg 7 = 0x11 (older) and reg 7 = 0x22 (younger) buffered with `rfBusy=1`, `lookupReg1=7`, `lookupReg2=31` → `fwdHit1=1`, `fwdData1=0x22`, `fwdHit2=0`.

Source files
------------

// File: rtl/write_back_unit_if.sv
// ---------------------------------------------------------------------------
// write_back_unit_if : MEM-stage result handshake plus register-file write port
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface write_back_unit_if;
   logic        memValid;
   logic        memReady;
   logic        regWriteIn;
   logic        memToReg;
   logic [4:0]  destReg;
   logic [31:0] aluResult;
   logic [31:0] memReadData;
   logic        rfBusy;
   logic        regWrite;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;

   modport master (
      output memValid, regWriteIn, memToReg, destReg, aluResult, memReadData, rfBusy,
      input  memReady, regWrite, writeRegister, writeData
   );

   modport slave (
      input  memValid, regWriteIn, memToReg, destReg, aluResult, memReadData, rfBusy,
      output memReady, regWrite, writeRegister, writeData
   );
endinterface

`default_nettype wire

// File: rtl/write_back_unit.sv
// ---------------------------------------------------------------------------
// write_back_unit : LEGv8 writeback stage, result FIFO feeding the RF write port
// Optional feature macro: WB_FORWARD_EN (combinational forwarding lookup)
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module write_back_unit #(
   parameter int DEPTH = 2
) (
   input  wire logic         clock,
   input  wire logic         resetN,
   write_back_unit_if.slave  bus,
`ifdef WB_FORWARD_EN
   input  wire logic [4:0]   lookupReg1,
   input  wire logic [4:0]   lookupReg2,
   output logic              fwdHit1,
   output logic              fwdHit2,
   output logic [31:0]       fwdData1,
   output logic [31:0]       fwdData2,
`endif
   output logic [15:0]       retireCount
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [4:0]    ent_reg_q  [DEPTH];
   logic [31:0]   ent_data_q [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          regWrite_q, regWrite_d;
   logic [4:0]    wreg_q, wreg_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [15:0]   retire_q, retire_d;

   logic          accept;
   logic          push;
   logic          pop;

   assign bus.memReady      = (count_q != CW'(DEPTH));
   assign accept            = bus.memValid && bus.memReady;
   // XZR targets and non-writing instructions are consumed without buffering.
   assign push              = accept && bus.regWriteIn && (bus.destReg != 5'd31);
   assign pop               = !bus.rfBusy && (count_q != '0);

   assign bus.regWrite      = regWrite_q;
   assign bus.writeRegister = wreg_q;
   assign bus.writeData     = wdata_q;
   assign retireCount       = retire_q;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      regWrite_d = 1'b0;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      retire_d   = retire_q;
      if (push) begin
         tail_d = tail_q + PW'(1);
      end
      if (pop) begin
         head_d     = head_q + PW'(1);
         regWrite_d = 1'b1;
         wreg_d     = ent_reg_q[head_q];
         wdata_d    = ent_data_q[head_q];
         retire_d   = retire_q + 16'd1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) begin
         ent_reg_q[tail_q]  <= bus.destReg;
         ent_data_q[tail_q] <= bus.memToReg ? bus.memReadData : bus.aluResult;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         regWrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
         retire_q   <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         regWrite_q <= regWrite_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
         retire_q   <= retire_d;
      end
   end

`ifdef WB_FORWARD_EN
   // Walk from head to tail so the youngest matching entry overrides older ones.
   function automatic logic [32:0] fwd_lookup(input logic [4:0] addr);
      logic [32:0]   res;
      logic [PW-1:0] idx;
      res = '0;
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if ((CW'(i) < count_q) && (addr != 5'd31) && (ent_reg_q[idx] == addr)) begin
            res = {1'b1, ent_data_q[idx]};
         end
      end
      return res;
   endfunction

   always_comb begin
      {fwdHit1, fwdData1} = fwd_lookup(lookupReg1);
      {fwdHit2, fwdData2} = fwd_lookup(lookupReg2);
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_write_back_unit.sv
// ---------------------------------------------------------------------------
// tb_write_back_unit : directed scoreboard bench for write_back_unit (DEPTH=2)
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_write_back_unit;

   logic        clock = 1'b0;
   logic        resetN;
   logic [15:0] retireCount;
`ifdef WB_FORWARD_EN
   logic [4:0]  lookupReg1, lookupReg2;
   logic        fwdHit1, fwdHit2;
   logic [31:0] fwdData1, fwdData2;
`endif

   always #5 clock = ~clock;

   write_back_unit_if bus ();

   write_back_unit #(.DEPTH(2)) dut (
      .clock       (clock),
      .resetN      (resetN),
      .bus         (bus.slave),
`ifdef WB_FORWARD_EN
      .lookupReg1  (lookupReg1),
      .lookupReg2  (lookupReg2),
      .fwdHit1     (fwdHit1),
      .fwdHit2     (fwdHit2),
      .fwdData1    (fwdData1),
      .fwdData2    (fwdData2),
`endif
      .retireCount (retireCount)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [36:0] sb[$];
   logic [15:0] exp_retire = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and compare any register-file write against the scoreboard.
   task automatic step();
      logic [36:0] e;
      @(posedge clock);
      #1;
      if (bus.regWrite === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 64'(bus.writeRegister), 64'hFFFF);
         end else begin
            e = sb.pop_front();
            exp_retire = exp_retire + 16'd1;
            check("wr_reg", 64'(bus.writeRegister), 64'(e[36:32]));
            check("wr_data", 64'(bus.writeData), 64'(e[31:0]));
            check("retire", 64'(retireCount), 64'(exp_retire));
         end
      end
   endtask

   task automatic offer(input logic [4:0] rd, input logic rw, input logic m2r,
                        input logic [31:0] alu, input logic [31:0] mem);
      bit done = 0;
      bus.memValid    = 1'b1;
      bus.destReg     = rd;
      bus.regWriteIn  = rw;
      bus.memToReg    = m2r;
      bus.aluResult   = alu;
      bus.memReadData = mem;
      for (int c = 0; c < 40 && !done; c++) begin
         if (bus.memReady === 1'b1) begin
            if (rw && rd != 5'd31) sb.push_back({rd, m2r ? mem : alu});
            done = 1;
         end
         step();
      end
      if (!done) check("accept_timeout", 64'd0, 64'd1);
      bus.memValid = 1'b0;
   endtask

   int cyc;

   initial begin
      bus.memValid    = 1'b0;
      bus.regWriteIn  = 1'b0;
      bus.memToReg    = 1'b0;
      bus.destReg     = '0;
      bus.aluResult   = '0;
      bus.memReadData = '0;
      bus.rfBusy      = 1'b0;
`ifdef WB_FORWARD_EN
      lookupReg1 = 5'd0;
      lookupReg2 = 5'd0;
`endif
      resetN = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      resetN = 1'b1;
      check("rst_regWrite", 64'(bus.regWrite), 64'd0);
      check("rst_wreg", 64'(bus.writeRegister), 64'd0);
      check("rst_wdata", 64'(bus.writeData), 64'd0);
      check("rst_retire", 64'(retireCount), 64'd0);
      check("rst_ready", 64'(bus.memReady), 64'd1);

      // Single ALU write with latency check
      offer(5'd5, 1'b1, 1'b0, 32'h0000_00AA, 32'hFFFF_0000);
      check("lat_edgeN", 64'(bus.regWrite), 64'd0);
      step();
      check("lat_edgeN1", 64'(bus.regWrite), 64'd1);
      check("single_retire", 64'(retireCount), 64'd1);
      step();
      check("single_deassert", 64'(bus.regWrite), 64'd0);
      check("single_hold_data", 64'(bus.writeData), 64'h0000_00AA);

      // Memory select, XZR drop, non-writing drop
      offer(5'd3, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      offer(5'd31, 1'b1, 1'b0, 32'h5555_5555, 32'h0);
      offer(5'd4, 1'b0, 1'b0, 32'h6666_6666, 32'h0);
      for (int i = 0; i < 4; i++) step();
      check("xzr_retire", 64'(retireCount), 64'd2);

      // Backpressure and full
      bus.rfBusy = 1'b1;
      offer(5'd10, 1'b1, 1'b0, 32'hA0A0_0001, 32'h0);
      offer(5'd11, 1'b1, 1'b1, 32'h0, 32'hB0B0_0002);
      bus.memValid   = 1'b1;
      bus.destReg    = 5'd12;
      bus.regWriteIn = 1'b1;
      bus.memToReg   = 1'b0;
      bus.aluResult  = 32'hC0C0_0003;
      check("full_ready", 64'(bus.memReady), 64'd0);
      step();
      step();
      check("busy_no_write", 64'(bus.regWrite), 64'd0);
      check("busy_still_full", 64'(bus.memReady), 64'd0);
      sb.push_back({5'd12, 32'hC0C0_0003});
      bus.rfBusy = 1'b0;
      step();
      check("drain1", 64'(bus.regWrite), 64'd1);
      check("drain1_ready", 64'(bus.memReady), 64'd1);
      step();
      bus.memValid = 1'b0;
      check("drain2_consec", 64'(bus.regWrite), 64'd1);
      step();
      check("drain3_consec", 64'(bus.regWrite), 64'd1);
      step();
      check("drain_done", 64'(bus.regWrite), 64'd0);

      // Reset mid-operation
      bus.rfBusy = 1'b1;
      offer(5'd20, 1'b1, 1'b0, 32'h2020_2020, 32'h0);
      offer(5'd21, 1'b1, 1'b0, 32'h2121_2121, 32'h0);
      bus.memValid   = 1'b1;
      bus.destReg    = 5'd9;
      bus.regWriteIn = 1'b1;
      bus.aluResult  = 32'h0909_0909;
      resetN = 1'b0;
      sb.delete();
      exp_retire = '0;
      step();
      resetN       = 1'b1;
      bus.memValid = 1'b0;
      bus.rfBusy   = 1'b0;
      check("mid_rst_regWrite", 64'(bus.regWrite), 64'd0);
      check("mid_rst_ready", 64'(bus.memReady), 64'd1);
      check("mid_rst_retire", 64'(retireCount), 64'd0);
      for (int i = 0; i < 4; i++) step();
      check("mid_rst_idle", 64'(bus.regWrite), 64'd0);

`ifdef WB_FORWARD_EN
      bus.rfBusy = 1'b1;
      offer(5'd7, 1'b1, 1'b0, 32'h0000_0011, 32'h0);
      offer(5'd7, 1'b1, 1'b0, 32'h0000_0022, 32'h0);
      lookupReg1 = 5'd7;
      lookupReg2 = 5'd31;
      #1;
      check("fwd_hit1", 64'(fwdHit1), 64'd1);
      check("fwd_data1", 64'(fwdData1), 64'h22);
      check("fwd_hit2_xzr", 64'(fwdHit2), 64'd0);
      lookupReg2 = 5'd8;
      #1;
      check("fwd_hit2_miss", 64'(fwdHit2), 64'd0);
      bus.rfBusy = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("fwd_empty_miss", 64'(fwdHit1), 64'd0);
`endif

      // Sustained throughput and retireCount wrap
      cyc = 0;
      while (exp_retire != 16'hFFFE) begin
         offer(5'(exp_retire % 30), 1'b1, 1'b0, {16'hC0DE, exp_retire}, 32'h0);
         cyc++;
         if (cyc > 70000) break;
      end
      check("throughput", 64'(cyc <= 65536), 64'd1);
      step();
      check("retire_ffff", 64'(retireCount), 64'hFFFF);
      offer(5'd1, 1'b1, 1'b0, 32'hFACE_0001, 32'h0);
      step();
      step();
      check("retire_wrap", 64'(retireCount), 64'h0000);

      for (int i = 0; i < 4; i++) step();
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
